sqrt_pipe_param: RTL and testbench
==================================

Name: sqrt_pipe_param

Overview:
Parametrised, fully pipelined unsigned integer square root using the digit-by-digit restoring method.
- Computes root = floor(sqrt(src)) and remainder = src - root^2, with optional round-to-nearest on the root.
- Adds a valid/ready handshake with full backpressure, a sideband tag carried alongside each operand, and a configurable number of root bits resolved per register stage.
- Sits in the same arithmetic library as the fixed 48-bit square root and replaces it wherever width, throughput/latency trade-off or flow control differ.

Parameters:
- IW, 48: input width in bits; must be even and ≥ 4. Output width OW = IW/2.
- BPS, 2: root bits resolved combinationally per pipeline stage; 1..OW. Number of stages NST = ceil(OW/BPS).
- ROUND, 0: 0 = floor root; 1 = round-to-nearest root with saturation.
- TAGW, 8: sideband tag width; ≥ 1.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- vldin, input, 1: input operand valid.
- rdyin, output, 1: block can accept an operand this cycle.
- src, input, IW: unsigned radicand.
- tagin, input, TAGW: sideband travelling with src.
- vldout, output, 1: result valid.
- rdyout, input, 1: downstream accepts the result.
- out, output, OW: root.
- rem, output, OW+1: src - floor_root^2. Always the floor remainder, independent of ROUND.
- tagout, output, TAGW: tag belonging to out.

Behaviour:
- Reset (async assert, sync deassert by the clk domain): all stage valid bits = 0, vldout = 0, out = 0, rem = 0, tagout = 0. Data registers other than outputs need not be reset.
- Pipeline: NST compute stages plus one output register. Latency from accepted input to vldout = NST+1 cycles when there is no stall. For IW=48, BPS=2: NST=12, latency 13.
- Stage k resolves root bits from MSB down, BPS bits per stage (the last stage may resolve fewer). Per bit i:
  - trial = acc + 2^(2i) + (root << (i+1));
  - if trial ≤ src: acc = trial, root bit i = 1.
  - acc is IW bits, root is OW bits.
  - src and tag travel with each stage.
- Advance enable: adv = !vldout | rdyout. All stages shift together when adv = 1 and hold when adv = 0 (global stall). rdyin = adv.
- Transfers:
  - An input transfer occurs when vldin & rdyin.
  - An output transfer occurs when vldout & rdyout.
  - Stage valid bits load the previous stage's valid when adv = 1; bubbles propagate as valid = 0.
- Throughput: one result per cycle while rdyout is held 1, with no gaps.
- Output data is stable while vldout = 1 and rdyout = 0; no output changes until the transfer.
- Remainder: rem = src - acc_final. Its range is 0..2*root, so it fits OW+1 bits.
- ROUND = 1:
  - out = root+1 when rem > root, else root.
  - If root = 2^OW-1 and rounding would overflow, out saturates to 2^OW-1.
- vldin with rdyin = 0: the operand is not taken. The source must hold it; the block ignores it.
- Reset mid-operation: all in-flight operands are discarded, no vldout after release until new inputs pass through, and rdyin = 1 in the first cycle after release.
- Simultaneous output transfer and new input in the same cycle: both occur and the pipeline advances.

Test Plan:
- IW=48, BPS=2, ROUND=0: src=0, tag=0x11 -> after 13 cycles vldout=1, out=0, rem=0, tagout=0x11.
- src=99 -> out=9, rem=18. Repeat with ROUND=1 -> out=10, rem=18.
- src=0xFFFFFFFFFFFF -> out=0xFFFFFF, rem=0x1FFFFFE. With ROUND=1, out stays 0xFFFFFF (saturated).
- Back-to-back inputs 0..1023 with rdyout=1:
  - one result per cycle, in order, tags preserved;
  - every result matches floor(sqrt(n)) and n - root^2.
- Random stream with rdyout toggled randomly:
  - no loss or duplication;
  - out/rem/tagout stable during stall;
  - rdyin=0 exactly when vldout=1 and rdyout=0.
- Pulse rst_n low with 5 operands in flight -> vldout=0 immediately, no stale results after release, next operand (src=144) returns out=12, rem=0 after 13 cycles.
- Repeat the exhaustive 0..65535 check for IW=16 with BPS in {1, 3, 8} -> latencies 9, 4, 2 respectively, all results correct.

Source files
------------

// File: rtl/sqrt_pipe_param_if.sv
// Handshake and data bundle for sqrt_pipe_param: operand in, root/remainder out.
interface sqrt_pipe_param_if #(
  parameter int unsigned IW   = 48,
  parameter int unsigned TAGW = 8
);
  localparam int unsigned OW = IW / 2;

  logic            vldin;
  logic            rdyin;
  logic [IW-1:0]   src;
  logic [TAGW-1:0] tagin;
  logic            vldout;
  logic            rdyout;
  logic [OW-1:0]   out;
  logic [OW:0]     rem;
  logic [TAGW-1:0] tagout;

  // Operand source / result sink side.
  modport master (
    output vldin, src, tagin, rdyout,
    input  rdyin, vldout, out, rem, tagout
  );

  // Square-root block side.
  modport slave (
    input  vldin, src, tagin, rdyout,
    output rdyin, vldout, out, rem, tagout
  );
endinterface

// File: rtl/sqrt_pipe_param.sv
// Fully pipelined restoring integer square root, BPS root bits per stage,
// global-stall valid/ready flow control, optional round-to-nearest root.
module sqrt_pipe_param #(
  parameter int unsigned IW    = 48,
  parameter int unsigned BPS   = 2,
  parameter int unsigned ROUND = 0,
  parameter int unsigned TAGW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sqrt_pipe_param_if.slave  bus
);
  localparam int unsigned OW  = IW / 2;
  localparam int unsigned NST = (OW + BPS - 1) / BPS;

  logic            adv;
  logic            valid_q [NST];
  logic [IW-1:0]   src_q   [NST];
  logic [IW-1:0]   acc_q   [NST];
  logic [OW-1:0]   root_q  [NST];
  logic [TAGW-1:0] tag_q   [NST];
  logic [IW-1:0]   acc_d   [NST];
  logic [OW-1:0]   root_d  [NST];

  logic            vldout_q;
  logic [OW-1:0]   out_q;
  logic [OW:0]     rem_q;
  logic [TAGW-1:0] tagout_q;

  // Whole pipeline moves as one; a held result freezes every stage.
  assign adv       = ~vldout_q | bus.rdyout;
  assign bus.rdyin = adv;

  for (genvar k = 0; k < int'(NST); k++) begin : g_stage
    logic [IW-1:0] acc_in;
    logic [IW-1:0] src_in;
    logic [OW-1:0] root_in;
    logic [IW-1:0] acc_w;
    logic [OW-1:0] root_w;
    logic [IW:0]   trial;
    int            bi;

    if (k == 0) begin : g_first
      assign acc_in  = '0;
      assign root_in = '0;
      assign src_in  = bus.src;
    end else begin : g_next
      assign acc_in  = acc_q[k-1];
      assign root_in = root_q[k-1];
      assign src_in  = src_q[k-1];
    end

    // Resolve this stage's root bits MSB first; trial = (root + 2^i)^2.
    always_comb begin
      acc_w  = acc_in;
      root_w = root_in;
      trial  = '0;
      bi     = 0;
      for (int j = 0; j < int'(BPS); j++) begin
        bi = int'(OW) - 1 - int'(k * BPS) - j;
        if (bi >= 0) begin
          trial = {1'b0, acc_w} + ({{IW{1'b0}}, 1'b1} << (2 * bi))
                + ({{(IW + 1 - OW){1'b0}}, root_w} << (bi + 1));
          if (trial <= {1'b0, src_in}) begin
            acc_w  = trial[IW-1:0];
            root_w = root_w | ({{(OW - 1){1'b0}}, 1'b1} << bi);
          end
        end
      end
    end

    assign acc_d[k]  = acc_w;
    assign root_d[k] = root_w;
  end

  // Stage valid bits: bubbles travel as zeros, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NST); k++) valid_q[k] <= 1'b0;
    end else if (adv) begin
      valid_q[0] <= bus.vldin;
      for (int k = 1; k < int'(NST); k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // Stage data: no reset needed, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      src_q[0] <= bus.src;
      tag_q[0] <= bus.tagin;
      for (int k = 1; k < int'(NST); k++) begin
        src_q[k] <= src_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      for (int k = 0; k < int'(NST); k++) begin
        acc_q[k]  <= acc_d[k];
        root_q[k] <= root_d[k];
      end
    end
  end

  logic [IW-1:0] rem_full;
  logic [OW:0]   rem_d;
  logic [OW-1:0] root_fin;
  logic [OW-1:0] out_d;
  logic          unused_rem_hi;

  // Remainder is at most 2*root, so only the low OW+1 bits are meaningful.
  assign root_fin      = root_q[NST-1];
  assign rem_full      = src_q[NST-1] - acc_q[NST-1];
  assign rem_d         = rem_full[OW:0];
  assign unused_rem_hi = ^rem_full[IW-1:OW+1];

  // Round up when the remainder exceeds the root, saturating at all-ones.
  always_comb begin
    out_d = root_fin;
    if ((ROUND != 0) && (rem_d > {1'b0, root_fin}) && (root_fin != '1)) begin
      out_d = root_fin + {{(OW - 1){1'b0}}, 1'b1};
    end
  end

  // Output register; data only updates with a valid result so a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldout_q <= 1'b0;
      out_q    <= '0;
      rem_q    <= '0;
      tagout_q <= '0;
    end else if (adv) begin
      vldout_q <= valid_q[NST-1];
      if (valid_q[NST-1]) begin
        out_q    <= out_d;
        rem_q    <= rem_d;
        tagout_q <= tag_q[NST-1];
      end
    end
  end

  assign bus.vldout = vldout_q;
  assign bus.out    = out_q;
  assign bus.rem    = rem_q;
  assign bus.tagout = tagout_q;
endmodule

// File: tb/tb_sqrt_pipe_param.sv
// Bench for sqrt_pipe_param: 48-bit floor and rounding instances driven in
// lockstep, plus three 16-bit instances (BPS 1, 3, 8) swept exhaustively.
module tb_sqrt_pipe_param;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sqrt_pipe_param_if #(.IW(48), .TAGW(8)) b48f ();
  sqrt_pipe_param_if #(.IW(48), .TAGW(8)) b48r ();

  assign b48r.vldin  = b48f.vldin;
  assign b48r.src    = b48f.src;
  assign b48r.tagin  = b48f.tagin;
  assign b48r.rdyout = b48f.rdyout;

  sqrt_pipe_param #(.IW(48), .BPS(2), .ROUND(0), .TAGW(8)) u_dut48f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b48f)
  );

  sqrt_pipe_param #(.IW(48), .BPS(2), .ROUND(1), .TAGW(8)) u_dut48r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b48r)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned n);
    real x;
    longint unsigned r;
    x = real'(n);
    r = longint'($floor($sqrt(x)));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // 48-bit scoreboard, stall-hold and rdyin checks
  typedef struct { logic [47:0] src; logic [7:0] tag; } in48_t;
  in48_t           q48[$];
  in48_t           e48;
  longint unsigned er, erem, ernd;
  logic            stall_prev = 1'b0;
  logic [23:0]     p_out, p_outr;
  logic [24:0]     p_rem;
  logic [7:0]      p_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      q48.delete();
      stall_prev = 1'b0;
    end else begin
      chk("rdyin rule", b48f.rdyin, !(b48f.vldout && !b48f.rdyout));
      if (stall_prev) begin
        chk("hold vldout", b48f.vldout, 1);
        chk("hold out", b48f.out, p_out);
        chk("hold rem", b48f.rem, p_rem);
        chk("hold tag", b48f.tagout, p_tag);
        chk("hold out rnd", b48r.out, p_outr);
      end
      stall_prev = b48f.vldout && !b48f.rdyout;
      p_out  = b48f.out;
      p_rem  = b48f.rem;
      p_tag  = b48f.tagout;
      p_outr = b48r.out;
      if (b48f.vldin && b48f.rdyin) q48.push_back('{b48f.src, b48f.tagin});
      if (b48f.vldout && b48f.rdyout) begin
        if (q48.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL s48 spurious result: got out 0x%0h, expected no result", b48f.out);
        end else begin
          e48  = q48.pop_front();
          er   = isqrt(64'(e48.src));
          erem = 64'(e48.src) - er * er;
          ernd = (erem > er && er != 64'hFFFFFF) ? er + 1 : er;
          chk("s48 out", b48f.out, er);
          chk("s48 rem", b48f.rem, erem);
          chk("s48 tag", b48f.tagout, e48.tag);
          chk("s48r vldout", b48r.vldout, 1);
          chk("s48r out", b48r.out, ernd);
          chk("s48r rem", b48r.rem, erem);
          chk("s48r tag", b48r.tagout, e48.tag);
        end
      end
    end
  end

  // 16-bit instances share one input stream
  logic        s16_vld = 1'b0;
  logic [15:0] s16_src = '0;
  logic [7:0]  s16_tag = '0;
  logic        s16_rdy = 1'b1;
  typedef struct { logic [15:0] src; logic [7:0] tag; int cyc; } in16_t;

  for (genvar g = 0; g < 3; g++) begin : g_w16
    localparam int unsigned Bps = (g == 0) ? 1 : (g == 1) ? 3 : 8;
    localparam int          Lat = (g == 0) ? 9 : (g == 1) ? 4 : 2;
    sqrt_pipe_param_if #(.IW(16), .TAGW(8)) bus16 ();
    in16_t           q16[$];
    in16_t           e;
    longint unsigned r;

    assign bus16.vldin  = s16_vld;
    assign bus16.src    = s16_src;
    assign bus16.tagin  = s16_tag;
    assign bus16.rdyout = s16_rdy;

    sqrt_pipe_param #(.IW(16), .BPS(Bps), .ROUND(0), .TAGW(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        q16.delete();
      end else begin
        if (bus16.vldin && bus16.rdyin) q16.push_back('{bus16.src, bus16.tagin, cyc});
        if (bus16.vldout && bus16.rdyout) begin
          if (q16.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL w16 bps%0d spurious: got out 0x%0h, expected none", Bps, bus16.out);
          end else begin
            e = q16.pop_front();
            r = isqrt(64'(e.src));
            chk($sformatf("w16 bps%0d out", Bps), bus16.out, r);
            chk($sformatf("w16 bps%0d rem", Bps), bus16.rem, 64'(e.src) - r * r);
            chk($sformatf("w16 bps%0d tag", Bps), bus16.tagout, e.tag);
            chk($sformatf("w16 bps%0d latency", Bps), 64'(cyc - e.cyc), 64'(Lat));
          end
        end
      end
    end
  end

  // Directed vectors: src, tag, floor root, rounded root, remainder
  typedef struct {
    logic [47:0] src;
    logic [7:0]  tag;
    logic [23:0] out_f;
    logic [23:0] out_r;
    logic [24:0] rem;
  } vec_t;
  vec_t vecs [13];

  task automatic run_vec(input vec_t v);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    b48f.vldin = 1'b1;
    b48f.src   = v.src;
    b48f.tagin = v.tag;
    @(posedge clk); #1;
    b48f.vldin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b48f.vldout) begin
        lat = k;
        break;
      end
    end
    chk("vec latency", 64'(lat), 13);
    chk("vec out", b48f.out, v.out_f);
    chk("vec rem", b48f.rem, v.rem);
    chk("vec tag", b48f.tagout, v.tag);
    chk("vec rnd vldout", b48r.vldout, 1);
    chk("vec rnd out", b48r.out, v.out_r);
    chk("vec rnd rem", b48r.rem, v.rem);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic        took;
    vecs[0]  = '{48'd0,            8'h11, 24'd0,       24'd0,       25'd0};
    vecs[1]  = '{48'd99,           8'h22, 24'd9,       24'd10,      25'd18};
    vecs[2]  = '{48'hFFFFFFFFFFFF, 8'h33, 24'hFFFFFF,  24'hFFFFFF,  25'h1FFFFFE};
    vecs[3]  = '{48'd1,            8'h44, 24'd1,       24'd1,       25'd0};
    vecs[4]  = '{48'd2,            8'h45, 24'd1,       24'd1,       25'd1};
    vecs[5]  = '{48'd3,            8'h46, 24'd1,       24'd2,       25'd2};
    vecs[6]  = '{48'd144,          8'h47, 24'd12,      24'd12,      25'd0};
    vecs[7]  = '{48'd156,          8'h48, 24'd12,      24'd12,      25'd12};
    vecs[8]  = '{48'd157,          8'h49, 24'd12,      24'd13,      25'd13};
    vecs[9]  = '{48'hFFFFFE000000, 8'h4A, 24'hFFFFFE,  24'hFFFFFF,  25'h1FFFFFC};
    vecs[10] = '{48'd1000000,      8'h4B, 24'd1000,    24'd1000,    25'd0};
    vecs[11] = '{48'h100000000,    8'h4C, 24'h10000,   24'h10000,   25'd0};
    vecs[12] = '{48'd8,            8'h4D, 24'd2,       24'd3,       25'd4};

    b48f.vldin  = 1'b0;
    b48f.src    = '0;
    b48f.tagin  = '0;
    b48f.rdyout = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset vldout", b48f.vldout, 0);
    chk("reset out", b48f.out, 0);
    chk("reset rem", b48f.rem, 0);
    chk("reset tagout", b48f.tagout, 0);
    chk("reset rdyin", b48f.rdyin, 1);
    chk("reset rnd vldout", b48r.vldout, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back 0..1023: results must emerge on consecutive cycles
    for (int m = 0; m < 1037; m++) begin
      @(posedge clk); #1;
      if (m < 1024) begin
        b48f.vldin = 1'b1;
        b48f.src   = 48'(m);
        b48f.tagin = m[7:0];
      end else begin
        b48f.vldin = 1'b0;
      end
      @(negedge clk);
      if (m >= 13) chk("stream gapless vldout", b48f.vldout, 1);
    end
    repeat (3) @(negedge clk);

    // Reset with results and operands in flight
    for (int m = 0; m < 18; m++) begin
      @(posedge clk); #1;
      b48f.vldin = 1'b1;
      b48f.src   = 48'(2000 + m * 7);
      b48f.tagin = 8'(m);
    end
    @(posedge clk); #1;
    b48f.vldin = 1'b0;
    @(negedge clk);
    chk("pre-reset vldout", b48f.vldout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset vldout", b48f.vldout, 0);
    chk("mid-reset out", b48f.out, 0);
    chk("mid-reset rem", b48f.rem, 0);
    chk("mid-reset tagout", b48f.tagout, 0);
    chk("mid-reset rnd vldout", b48r.vldout, 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdyin after release", b48f.rdyin, 1);
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      chk("no stale vldout", b48f.vldout, 0);
    end
    run_vec(vecs[6]);

    // Random stream with random backpressure; source holds until accepted
    took = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!b48f.vldin || took) begin
        b48f.vldin = ($urandom_range(0, 3) != 0);
        r64 = {$urandom(), $urandom()};
        if ($urandom_range(0, 2) == 0) r64 = r64 >> $urandom_range(0, 47);
        b48f.src   = r64[47:0];
        b48f.tagin = 8'($urandom());
      end
      b48f.rdyout = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = b48f.vldin && b48f.rdyin;
    end
    @(posedge clk); #1;
    b48f.vldin  = 1'b0;
    b48f.rdyout = 1'b1;
    for (int c = 0; c < 40 && q48.size() != 0; c++) @(negedge clk);
    chk("random drain", 64'(q48.size()), 0);

    // Exhaustive 16-bit sweep through all three BPS variants
    for (int n = 0; n < 65536; n++) begin
      @(posedge clk); #1;
      s16_vld = 1'b1;
      s16_src = n[15:0];
      s16_tag = n[7:0];
    end
    @(posedge clk); #1;
    s16_vld = 1'b0;
    repeat (14) @(negedge clk);
    chk("w16 bps1 drain", 64'(g_w16[0].q16.size()), 0);
    chk("w16 bps3 drain", 64'(g_w16[1].q16.size()), 0);
    chk("w16 bps8 drain", 64'(g_w16[2].q16.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
